// File: rtl/det_4x4_issuer.sv
// det_4x4_issuer: host-side initiator for the 4x4 determinant core.
// Collects 16 signed elements from the host, fires the core with a one-cycle
// start pulse, waits for a rising edge on the core's done, and hands the
// result back to the host over a valid/ready handshake.
// Optional feature macro: DET_TIMEOUT_EN enables the WAIT-state watchdog.
module det_4x4_issuer #(
    parameter int DATA_W         = 8,
    parameter int RES_W          = 16,
    parameter int N_ELEM         = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   in_data,
    input  logic                       in_clear,
    output logic [N_ELEM*DATA_W-1:0]   mat_flat,
    output logic                       det_start,
    input  logic                       det_done,
    input  logic signed [RES_W-1:0]    det_result,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic signed [RES_W-1:0]    res_data,
    output logic                       busy,
    output logic                       err_timeout
);

    localparam int              CNT_W    = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ELEM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                     r_state;
    logic [CNT_W-1:0]           r_count;
    logic [N_ELEM*DATA_W-1:0]   r_mat_flat;
    logic                       r_done_q;
    logic                       r_res_valid;
    logic signed [RES_W-1:0]    r_res_data;

    logic                       w_accept_phase;
    logic                       w_done_rise;

`ifdef DET_TIMEOUT_EN
    localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0]            r_timer;
    logic                       r_err_timeout;

    assign err_timeout = r_err_timeout;
`else
    // Keeps the watchdog parameter referenced when the watchdog is compiled out.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign err_timeout = 1'b0;
`endif

    // Host-facing control decoded from the current state.
    assign w_accept_phase = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign in_ready       = w_accept_phase;
    assign det_start      = (r_state == S_FIRE);
    assign busy           = (r_state == S_FIRE) || (r_state == S_WAIT) || (r_state == S_HOLD);

    // A done level left over from an earlier run is not a completion; only a
    // fresh low-to-high transition counts.
    assign w_done_rise    = det_done & ~r_done_q;

    assign mat_flat       = r_mat_flat;
    assign res_valid      = r_res_valid;
    assign res_data       = r_res_data;

    // Issuer state machine: element capture, start pulse, completion wait, result hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_mat_flat    <= '0;
            r_done_q      <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
`ifdef DET_TIMEOUT_EN
            r_timer       <= '0;
            r_err_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (in_clear) begin
                        // Abort wins over a same-cycle transfer; stored elements stay put.
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end else if (in_valid) begin
                        for (int k = 0; k < N_ELEM; k++) begin
                            if (r_count == CNT_W'(k)) begin
                                r_mat_flat[k*DATA_W +: DATA_W] <= in_data;
                            end
                        end
                        if (r_count == LAST_IDX) begin
                            r_count <= '0;
                            r_state <= S_FIRE;
                        end else begin
                            r_count <= r_count + 1'b1;
                            r_state <= S_LOAD;
                        end
                    end
                end

                S_FIRE: begin
                    // Sampling done here hides an edge that coincides with the start pulse.
                    r_done_q <= det_done;
`ifdef DET_TIMEOUT_EN
                    r_timer  <= '0;
`endif
                    r_state  <= S_WAIT;
                end

                S_WAIT: begin
                    r_done_q <= det_done;
                    if (w_done_rise) begin
                        r_res_data  <= det_result;
                        r_res_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
`ifdef DET_TIMEOUT_EN
                    else if (r_timer == TO_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_res_data    <= '0;
                        r_res_valid   <= 1'b1;
                        r_state       <= S_HOLD;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
`endif
                end

                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_det_4x4_issuer.sv
// tb_det_4x4_issuer: directed bench for det_4x4_issuer. The core is played by
// the bench, which drives det_done/det_result by hand. Define DET_TIMEOUT_EN to
// also exercise the watchdog (TIMEOUT_CYCLES is set to 8 here).
module tb_det_4x4_issuer;

    localparam int DATA_W = 8;
    localparam int RES_W  = 16;
    localparam int N_ELEM = 16;

    logic                      clk;
    logic                      rst_n;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [DATA_W-1:0]  in_data;
    logic                      in_clear;
    logic [N_ELEM*DATA_W-1:0]  mat_flat;
    logic                      det_start;
    logic                      det_done;
    logic signed [RES_W-1:0]   det_result;
    logic                      res_valid;
    logic                      res_ready;
    logic signed [RES_W-1:0]   res_data;
    logic                      busy;
    logic                      err_timeout;

    int n_checks = 0;
    int n_err    = 0;
    int n_start  = 0;
    int exp_starts = 0;

    logic [7:0]               vec [16];
    logic [N_ELEM*DATA_W-1:0] exp_mat;
    logic                     hold_ok;

    det_4x4_issuer #(
        .DATA_W         (DATA_W),
        .RES_W          (RES_W),
        .N_ELEM         (N_ELEM),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_clear    (in_clear),
        .mat_flat    (mat_flat),
        .det_start   (det_start),
        .det_done    (det_done),
        .det_result  (det_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count start pulses, sampled mid-cycle.
    always @(negedge clk) if (rst_n && det_start) n_start++;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec();
        for (int k = 0; k < N_ELEM; k++) begin
            in_valid = 1'b1;
            in_data  = vec[k];
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic build_exp();
        for (int k = 0; k < N_ELEM; k++) exp_mat[k*DATA_W +: DATA_W] = vec[k];
    endtask

    task automatic drain(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_drain_valid"}, res_valid, 1'b0);
        chk({tag, "_drain_ready"}, in_ready, 1'b1);
        chk({tag, "_drain_busy"}, busy, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_clear   = 1'b0;
        det_done   = 1'b0;
        det_result = '0;
        res_ready  = 1'b0;

        // Reset state
        #3;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_det_start", det_start, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_data", {res_data}, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mat_flat", mat_flat, '0);
        chk("rst_err_timeout", err_timeout, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: reference matrix, determinant 7
        vec = '{8'd2, 8'd1, 8'd2, 8'd2, 8'd1, 8'd2, 8'd3, 8'd1,
                8'd2, 8'd2, 8'd1, 8'd2, 8'd2, 8'd1, 8'd1, 8'd1};
        build_exp();
        load_vec();
        exp_starts++;
        chk("t1_start_high", det_start, 1'b1);
        chk("t1_ready_low", in_ready, 1'b0);
        chk("t1_busy", busy, 1'b1);
        chk("t1_mat_a", mat_flat[7:0], 8'd2);
        chk("t1_mat_all", mat_flat, exp_mat);
        tick();
        chk("t1_start_one_cycle", det_start, 1'b0);
        chk("t1_no_result_yet", res_valid, 1'b0);
        det_done   = 1'b1;
        det_result = 16'sd7;
        tick();
        chk("t1_res_valid", res_valid, 1'b1);
        chk("t1_res_data", {res_data}, 16'd7);
        chk("t1_hold_ready", in_ready, 1'b0);
        chk("t1_start_count", n_start, exp_starts);
        det_done = 1'b0;
        drain("t1");

        // 2: identity matrix, host stalls the result for 10 cycles
        for (int k = 0; k < N_ELEM; k++) vec[k] = (k % 5 == 0) ? 8'd1 : 8'd0;
        build_exp();
        load_vec();
        exp_starts++;
        tick();
        det_done   = 1'b1;
        det_result = 16'sd1;
        tick();
        det_done   = 1'b0;
        det_result = 16'sd99;
        in_valid   = 1'b1;
        in_data    = 8'h55;
        hold_ok    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_valid !== 1'b1 || res_data !== 16'sd1 || in_ready !== 1'b0 ||
                busy !== 1'b1 || mat_flat !== exp_mat) hold_ok = 1'b0;
        end
        in_valid = 1'b0;
        chk("t2_hold_stable", hold_ok, 1'b1);
        chk("t2_res_data", {res_data}, 16'd1);
        drain("t2");

        // 3: partial load aborted by in_clear (same-cycle element dropped)
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'sd9;
            tick();
        end
        in_clear = 1'b1;
        in_data  = 8'hAB;
        tick();
        in_clear = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) exp_mat[k*DATA_W +: DATA_W] = 8'd9;
        chk("t3_clear_mat", mat_flat, exp_mat);
        chk("t3_clear_ready", in_ready, 1'b1);
        chk("t3_clear_busy", busy, 1'b0);
        for (int k = 0; k < N_ELEM; k++) vec[k] = 8'(8'hF0 + k);
        build_exp();
        for (int k = 0; k < N_ELEM - 1; k++) begin
            in_valid = 1'b1;
            in_data  = vec[k];
            tick();
        end
        in_valid = 1'b0;
        chk("t3_no_early_start", det_start, 1'b0);
        chk("t3_still_ready", in_ready, 1'b1);
        chk("t3_start_count_15", n_start, exp_starts);
        in_valid = 1'b1;
        in_data  = vec[N_ELEM-1];
        tick();
        in_valid = 1'b0;
        exp_starts++;
        chk("t3_start_on_16", det_start, 1'b1);
        chk("t3_mat_all", mat_flat, exp_mat);
        tick();
        det_done   = 1'b1;
        det_result = -16'sd100;
        tick();
        chk("t3_res_neg", {res_data}, 16'hFF9C);

        // 4: done still high from the previous run must not complete the next
        for (int k = 0; k < N_ELEM; k++) vec[k] = 8'd3;
        drain("t3");
        load_vec();
        exp_starts++;
        tick();
        det_result = 16'sd77;
        tick();
        tick();
        tick();
        chk("t4_stale_done_ignored", res_valid, 1'b0);
        chk("t4_busy_waiting", busy, 1'b1);
        det_done = 1'b0;
        tick();
        chk("t4_fall_no_result", res_valid, 1'b0);
        det_done   = 1'b1;
        det_result = 16'sh0042;
        tick();
        chk("t4_res_valid", res_valid, 1'b1);
        chk("t4_res_data", {res_data}, 16'h0042);
        drain("t4");
        det_done = 1'b0;

        // 5: asynchronous reset while waiting on the core
        for (int k = 0; k < N_ELEM; k++) vec[k] = 8'(3 * k);
        load_vec();
        exp_starts++;
        tick();
        chk("t5_in_wait", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_start", det_start, 1'b0);
        chk("t5_rst_valid", res_valid, 1'b0);
        chk("t5_rst_data", {res_data}, 16'h0000);
        chk("t5_rst_mat", mat_flat, '0);
        chk("t5_rst_ready", in_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        det_done   = 1'b1;
        det_result = 16'sd5;
        tick();
        tick();
        chk("t5_late_done_valid", res_valid, 1'b0);
        chk("t5_late_done_busy", busy, 1'b0);
        det_done = 1'b0;
        tick();

`ifdef DET_TIMEOUT_EN
        // 6: watchdog fires 8 cycles after entering WAIT
        for (int k = 0; k < N_ELEM; k++) vec[k] = 8'd1;
        load_vec();
        exp_starts++;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("t6_before_limit", res_valid, 1'b0);
        chk("t6_no_err_yet", err_timeout, 1'b0);
        tick();
        chk("t6_err", err_timeout, 1'b1);
        chk("t6_valid", res_valid, 1'b1);
        chk("t6_data", {res_data}, 16'h0000);
        drain("t6");
        chk("t6_err_sticky", err_timeout, 1'b1);
`else
        chk("no_watchdog_err", err_timeout, 1'b0);
`endif

        chk("start_pulse_total", n_start, exp_starts);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
